// File: rtl/multiport_regfile.sv
// Multi-port register file: two byte-masked write ports, NUM_RD registered read ports, sweep clear.
// Optional macro REGFILE_BYPASS_EN forwards same-edge write data to the read ports.
module multiport_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we0,
    input  logic                         we1,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic [DATA_WIDTH/8-1:0]      wbe0,
    input  logic [DATA_WIDTH/8-1:0]      wbe1,
    input  logic [NUM_RD-1:0]            re,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rvalid,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         wr_drop
);

    localparam int DEPTH     = 2**ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                             state_reg, state_next;
    logic [ADDR_WIDTH-1:0]              sweep_addr_reg, sweep_addr_next;
    logic                               wr_drop_reg, wr_drop_next;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]   regs_reg;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]   regs_next;
    logic                               clr_active;
    logic [ADDR_WIDTH-1:0]              clr_addr;
    logic                               wr_ok;

    always_comb begin
        state_next      = state_reg;
        sweep_addr_next = sweep_addr_reg;
        clr_active      = 1'b0;
        clr_addr        = '0;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next      = SWEEP;
                    sweep_addr_next = ADDR_WIDTH'(1);
                    clr_active      = 1'b1;
                end
            end
            SWEEP: begin
                clr_active      = 1'b1;
                clr_addr        = sweep_addr_reg;
                sweep_addr_next = sweep_addr_reg + ADDR_WIDTH'(1);
                if (sweep_addr_reg == {ADDR_WIDTH{1'b1}})
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The accepting edge and every sweep edge own the array, so writes there are dropped.
    assign wr_ok        = !clr_active;
    assign wr_drop_next = clr_active && (we0 || we1);
    assign clr_busy     = (state_reg == SWEEP);
    assign wr_drop      = wr_drop_reg;

    genvar gi, gb;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic hit0, hit1, hit_clr, force_zero;
            assign hit0       = wr_ok && we0 && (waddr0 == ADDR_WIDTH'(gi));
            assign hit1       = wr_ok && we1 && (waddr1 == ADDR_WIDTH'(gi));
            assign hit_clr    = clr_active && (clr_addr == ADDR_WIDTH'(gi));
            assign force_zero = (ZERO_REG != 0) && (gi == 0);
            for (gb = 0; gb < NUM_BYTES; gb++) begin : g_byte
                // Port 1 wins bytes enabled on both ports.
                assign regs_next[gi][gb*8 +: 8] =
                    (hit_clr || force_zero) ? 8'h00 :
                    (hit1 && wbe1[gb])      ? wdata1[gb*8 +: 8] :
                    (hit0 && wbe0[gb])      ? wdata0[gb*8 +: 8] :
                                              regs_reg[gi][gb*8 +: 8];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sweep_addr_reg <= '0;
            wr_drop_reg    <= 1'b0;
            regs_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_addr_reg <= sweep_addr_next;
            wr_drop_reg    <= wr_drop_next;
            regs_reg       <= regs_next;
        end
    end

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] word;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  rvalid_reg;

            assign ra = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
            assign word = regs_next[ra];
`else
            assign word = regs_reg[ra];
`endif

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= re[gi];
                    if (re[gi])
                        rdata_reg <= ((ZERO_REG != 0) && (ra == '0)) ? '0 : word;
                end
            end

            assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg;
            assign rvalid[gi]                         = rvalid_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Scoreboard bench for multiport_regfile: read expectations queued at issue, popped on rvalid.
module tb_multiport_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [3:0]  wbe0 = '0, wbe1 = '0;
    logic [1:0]  re = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rvalid;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        wr_drop;

    int checks = 0;
    int errors = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mon_exp0, mon_exp1;

    multiport_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .wbe0(wbe0), .wbe1(wbe1),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
        .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: pops one expectation per port whenever the DUT presents read data.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (rvalid[0]) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd0_unexpected: got rvalid %b expected no read", rvalid[0]);
                end else begin
                    mon_exp0 = q0.pop_front();
                    chk("rd0", {32'h0, rdata[31:0]}, {32'h0, mon_exp0});
                end
            end
            if (rvalid[1]) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd1_unexpected: got rvalid %b expected no read", rvalid[1]);
                end else begin
                    mon_exp1 = q1.pop_front();
                    chk("rd1", {32'h0, rdata[63:32]}, {32'h0, mon_exp1});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; re = '0; clr_req = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            we0 = 1'b1; waddr0 = a; wdata0 = d; wbe0 = be;
        end else begin
            we1 = 1'b1; waddr1 = a; wdata1 = d; wbe1 = be;
        end
    endtask

    task automatic rd(input int k, input logic [4:0] a, input logic [31:0] e);
        re[k] = 1'b1;
        raddr[k*5 +: 5] = a;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    initial begin
        int busy_cnt;
        logic [7:0] b;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_rvalid", {62'h0, rvalid}, 64'h0);
        chk("rst_rdata", rdata, 64'h0);
        chk("rst_busy", {63'h0, clr_busy}, 64'h0);
        chk("rst_drop", {63'h0, wr_drop}, 64'h0);
        repeat (2) step();
        rst_n = 1'b1;

        // Basic write then read.
        wr(0, 5'd3, 32'hDEADBEEF, 4'hF); step(); idle();
        rd(0, 5'd3, 32'hDEADBEEF); step(); idle();

        // Same-address byte-merge conflict.
        wr(0, 5'd5, 32'h11223344, 4'hF); step(); idle();
        wr(0, 5'd5, 32'hAAAAAAAA, 4'h3); wr(1, 5'd5, 32'hBBBBBBBB, 4'h6); step(); idle();
        rd(1, 5'd5, 32'h11BBBBAA); step(); idle();

        // Same-edge read/write.
        wr(0, 5'd7, 32'h1, 4'hF); step(); idle();
        wr(0, 5'd7, 32'h2, 4'hF);
`ifdef REGFILE_BYPASS_EN
        rd(0, 5'd7, 32'h2);
`else
        rd(0, 5'd7, 32'h1);
`endif
        step(); idle();
        rd(0, 5'd7, 32'h2); step(); idle();

        // Register zero ignores writes silently.
        wr(1, 5'd0, 32'hFFFFFFFF, 4'hF); step(); idle();
        chk("zero_no_drop", {63'h0, wr_drop}, 64'h0);
        rd(0, 5'd0, 32'h0); rd(1, 5'd3, 32'hDEADBEEF); step(); idle();

        // re=0 keeps rdata and drops rvalid.
        step();
        chk("hold_rvalid", {62'h0, rvalid}, 64'h0);
        chk("hold_rdata1", {32'h0, rdata[63:32]}, 64'hDEADBEEF);

        // Partial single-port byte write.
        wr(0, 5'd9, 32'h01020304, 4'hF); step(); idle();
        wr(0, 5'd9, 32'hA0B0C0D0, 4'h9); step(); idle();
        rd(0, 5'd9, 32'hA00203D0); step(); idle();

        // Fill every register with a nonzero pattern.
        for (int a = 1; a < 32; a++) begin
            b = 8'(a);
            wr(0, 5'(a), {4{b}}, 4'hF); step(); idle();
        end
        rd(0, 5'd10, 32'h0A0A0A0A); rd(1, 5'd31, 32'h1F1F1F1F); step(); idle();

        // Clear sweep, write on the accepting edge is discarded.
        clr_req = 1'b1; wr(0, 5'd4, 32'h55, 4'hF); step(); idle();
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!clr_busy) break;
            busy_cnt++;
            if (i == 0) chk("drop_accept", {63'h0, wr_drop}, 64'h1);
            if (i == 1) chk("drop_quiet", {63'h0, wr_drop}, 64'h0);
            if (i == 5) begin
                wr(0, 5'd30, 32'h77, 4'hF);
                rd(0, 5'd3, 32'h0);
                rd(1, 5'd20, 32'h14141414);
            end
            if (i == 6) chk("drop_busy", {63'h0, wr_drop}, 64'h1);
            if (i == 7) chk("drop_pulse_end", {63'h0, wr_drop}, 64'h0);
            if (i == 10) clr_req = 1'b1;
            step(); idle();
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd31);
        for (int a = 0; a < 32; a++) begin
            rd(0, 5'(a), 32'h0); rd(1, 5'(31 - a), 32'h0); step(); idle();
        end

        // Reset in the middle of a sweep.
        wr(0, 5'd12, 32'hCAFE0001, 4'hF); wr(1, 5'd25, 32'h25252525, 4'hF); step(); idle();
        clr_req = 1'b1; step(); idle();
        step(); step();
        rd(0, 5'd12, 32'hCAFE0001); step(); idle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'h0, clr_busy}, 64'h0);
        chk("mid_rst_rvalid", {62'h0, rvalid}, 64'h0);
        chk("mid_rst_rdata", rdata, 64'h0);
        chk("mid_rst_drop", {63'h0, wr_drop}, 64'h0);
        step();
        rst_n = 1'b1;
        wr(0, 5'd12, 32'h12345678, 4'hF); rd(1, 5'd25, 32'h0); step(); idle();
        chk("post_rst_busy", {63'h0, clr_busy}, 64'h0);
        chk("post_rst_drop", {63'h0, wr_drop}, 64'h0);
        rd(0, 5'd12, 32'h12345678); step(); idle();

        repeat (3) step();
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
